// File: rtl/advtim_dt_brk_gen.sv
`default_nettype none
// ============================================================================
// Module : advtim_dt_brk_gen
// Desc   : Complementary output pairs with dead time, polarity, idle levels,
//          plus synchronised/filtered/latched break input.
// Rev    : 1.0  initial release
// ============================================================================
module advtim_dt_brk_gen #(
    parameter int DT_W  = 8,
    parameter int BKF_W = 4
) (
    input  logic             pe_gen_clk,
    input  logic             pe_gen_rstn,
    input  logic             oc1refc,
    input  logic             oc2refc,
    input  logic             oc3refc,
    input  logic [DT_W-1:0]  r_dtg,
    input  logic             r_cc1e,
    input  logic             r_cc2e,
    input  logic             r_cc3e,
    input  logic             r_cc1ne,
    input  logic             r_cc2ne,
    input  logic             r_cc3ne,
    input  logic             r_cc1p,
    input  logic             r_cc2p,
    input  logic             r_cc3p,
    input  logic             r_cc1np,
    input  logic             r_cc2np,
    input  logic             r_cc3np,
    input  logic             r_ois1,
    input  logic             r_ois2,
    input  logic             r_ois3,
    input  logic             r_ois1n,
    input  logic             r_ois2n,
    input  logic             r_ois3n,
    input  logic             r_moe,
    input  logic             r_bke,
    input  logic             r_bkp,
    input  logic [BKF_W-1:0] r_bkf,
    input  logic             r_brk_clr,
    input  logic             brk_in,
    output logic             oc1,
    output logic             oc2,
    output logic             oc3,
    output logic             oc1n,
    output logic             oc2n,
    output logic             oc3n,
    output logic             fault_detected,
    output logic             int_status_brk
);

    typedef enum logic [1:0] {
        MAIN_ON    = 2'd0,
        COMP_ON    = 2'd1,
        DT_TO_MAIN = 2'd2,
        DT_TO_COMP = 2'd3
    } state_t;

    logic [2:0] w_ref, w_cce, w_ccne, w_ccp, w_ccnp, w_ois, w_oisn;
    logic [2:0] w_oc, w_ocn;
    logic       w_dt_zero;
    logic       w_active;

    assign w_ref  = {oc3refc, oc2refc, oc1refc};
    assign w_cce  = {r_cc3e,  r_cc2e,  r_cc1e};
    assign w_ccne = {r_cc3ne, r_cc2ne, r_cc1ne};
    assign w_ccp  = {r_cc3p,  r_cc2p,  r_cc1p};
    assign w_ccnp = {r_cc3np, r_cc2np, r_cc1np};
    assign w_ois  = {r_ois3,  r_ois2,  r_ois1};
    assign w_oisn = {r_ois3n, r_ois2n, r_ois1n};

    assign w_dt_zero = (r_dtg == '0);

    // ------------------------------------------------------------------------
    // Break path
    // ------------------------------------------------------------------------
    logic             r_brk_s1, r_brk_s2;
    logic [BKF_W-1:0] r_bkf_cnt;
    logic             r_brk_latch, r_fault;
    logic             w_brk_smp, w_brk_det;
    logic [BKF_W-1:0] w_bkf_now;

    assign w_brk_smp = r_brk_s2 ^ ~r_bkp;
    // Count including the current sample, saturating at all-ones.
    assign w_bkf_now = (&r_bkf_cnt) ? r_bkf_cnt
                                    : r_bkf_cnt + {{(BKF_W-1){1'b0}}, 1'b1};
    assign w_brk_det = w_brk_smp & (w_bkf_now >= r_bkf);

    always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
        if (!pe_gen_rstn) begin
            r_brk_s1    <= 1'b0;
            r_brk_s2    <= 1'b0;
            r_bkf_cnt   <= '0;
            r_brk_latch <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_brk_s1  <= brk_in;
            r_brk_s2  <= r_brk_s1;
            r_bkf_cnt <= w_brk_smp ? w_bkf_now : '0;
            r_fault   <= w_brk_det & r_bke & ~r_brk_latch;
            if (w_brk_det && r_bke) begin
                r_brk_latch <= 1'b1;
            end else if (r_brk_clr && !w_brk_det) begin
                r_brk_latch <= 1'b0;
            end
        end
    end

    assign w_active = r_moe & ~r_brk_latch;

    // ------------------------------------------------------------------------
    // Per-channel dead-time FSM and registered output mux
    // ------------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        state_t          r_state, w_nstate;
        logic [DT_W-1:0] r_cnt, w_ncnt;
        logic [DT_W-1:0] r_dtg_l, w_ndtg_l;
        logic [DT_W:0]   w_cnt_inc;
        logic            r_ref_q;
        logic            r_oc_b, r_ocn_b;
        logic            w_m, w_c;

        always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
            if (!pe_gen_rstn) begin
                r_ref_q <= 1'b0;
                r_state <= DT_TO_COMP;
                r_cnt   <= '0;
                r_dtg_l <= '0;
            end else begin
                r_ref_q <= w_ref[gi];
                r_state <= w_nstate;
                r_cnt   <= w_ncnt;
                r_dtg_l <= w_ndtg_l;
            end
        end

        always_comb begin
            w_nstate  = r_state;
            w_ncnt    = r_cnt;
            w_ndtg_l  = r_dtg_l;
            w_cnt_inc = {1'b0, r_cnt} + {{DT_W{1'b0}}, 1'b1};
            case (r_state)
                MAIN_ON: begin
                    if (!r_ref_q) begin
                        w_ncnt   = '0;
                        w_ndtg_l = r_dtg;
                        w_nstate = w_dt_zero ? COMP_ON : DT_TO_COMP;
                    end
                end
                COMP_ON: begin
                    if (r_ref_q) begin
                        w_ncnt   = '0;
                        w_ndtg_l = r_dtg;
                        w_nstate = w_dt_zero ? MAIN_ON : DT_TO_MAIN;
                    end
                end
                DT_TO_MAIN: begin
                    if (!r_ref_q) begin
                        w_ncnt   = '0;
                        w_ndtg_l = r_dtg;
                        w_nstate = w_dt_zero ? COMP_ON : DT_TO_COMP;
                    end else if (w_cnt_inc >= {1'b0, r_dtg_l}) begin
                        w_ncnt   = '0;
                        w_nstate = MAIN_ON;
                    end else begin
                        w_ncnt = w_cnt_inc[DT_W-1:0];
                    end
                end
                DT_TO_COMP: begin
                    if (r_ref_q) begin
                        w_ncnt   = '0;
                        w_ndtg_l = r_dtg;
                        w_nstate = w_dt_zero ? MAIN_ON : DT_TO_MAIN;
                    end else if (w_cnt_inc >= {1'b0, r_dtg_l}) begin
                        w_ncnt   = '0;
                        w_nstate = COMP_ON;
                    end else begin
                        w_ncnt = w_cnt_inc[DT_W-1:0];
                    end
                end
                default: begin
                    w_ncnt   = '0;
                    w_nstate = DT_TO_COMP;
                end
            endcase
        end

        // Outputs are taken from the next state so the pair lands two clocks after ref.
        assign w_m = (w_nstate == MAIN_ON);
        assign w_c = (w_nstate == COMP_ON);

        always_ff @(posedge pe_gen_clk or negedge pe_gen_rstn) begin
            if (!pe_gen_rstn) begin
                r_oc_b  <= 1'b0;
                r_ocn_b <= 1'b0;
            end else if (w_active) begin
                r_oc_b  <= w_cce[gi]  ? (w_m ^ w_ccp[gi])  : w_ccp[gi];
                r_ocn_b <= w_ccne[gi] ? (w_c ^ w_ccnp[gi]) : w_ccnp[gi];
            end else begin
                r_oc_b  <= w_ois[gi];
                r_ocn_b <= w_oisn[gi];
            end
        end

        assign w_oc[gi]  = r_oc_b;
        assign w_ocn[gi] = r_ocn_b;
    end

    assign oc1            = w_oc[0];
    assign oc2            = w_oc[1];
    assign oc3            = w_oc[2];
    assign oc1n           = w_ocn[0];
    assign oc2n           = w_ocn[1];
    assign oc3n           = w_ocn[2];
    assign fault_detected = r_fault;
    assign int_status_brk = r_brk_latch;

endmodule
`default_nettype wire

// File: tb/tb_advtim_dt_brk_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_advtim_dt_brk_gen
// Desc   : Self-checking bench for advtim_dt_brk_gen (vector table, PWM
//          scoreboard, break and reset sequences).
// Rev    : 1.0  initial release
// ============================================================================
module tb_advtim_dt_brk_gen;

    localparam int HN = 8192;

    logic       clk;
    logic       rst_n;
    logic [2:0] ref_v, cce, ccne, ccp, ccnp, ois, oisn;
    logic [7:0] dtg;
    logic       moe, bke, bkp, brk_clr, brk_in;
    logic [3:0] bkf;
    logic       oc1, oc2, oc3, oc1n, oc2n, oc3n, fault_detected, int_status_brk;
    logic [2:0] oc_v, ocn_v;

    assign oc_v  = {oc3, oc2, oc1};
    assign ocn_v = {oc3n, oc2n, oc1n};

    advtim_dt_brk_gen dut (
        .pe_gen_clk     (clk),
        .pe_gen_rstn    (rst_n),
        .oc1refc        (ref_v[0]),
        .oc2refc        (ref_v[1]),
        .oc3refc        (ref_v[2]),
        .r_dtg          (dtg),
        .r_cc1e         (cce[0]),
        .r_cc2e         (cce[1]),
        .r_cc3e         (cce[2]),
        .r_cc1ne        (ccne[0]),
        .r_cc2ne        (ccne[1]),
        .r_cc3ne        (ccne[2]),
        .r_cc1p         (ccp[0]),
        .r_cc2p         (ccp[1]),
        .r_cc3p         (ccp[2]),
        .r_cc1np        (ccnp[0]),
        .r_cc2np        (ccnp[1]),
        .r_cc3np        (ccnp[2]),
        .r_ois1         (ois[0]),
        .r_ois2         (ois[1]),
        .r_ois3         (ois[2]),
        .r_ois1n        (oisn[0]),
        .r_ois2n        (oisn[1]),
        .r_ois3n        (oisn[2]),
        .r_moe          (moe),
        .r_bke          (bke),
        .r_bkp          (bkp),
        .r_bkf          (bkf),
        .r_brk_clr      (brk_clr),
        .brk_in         (brk_in),
        .oc1            (oc1),
        .oc2            (oc2),
        .oc3            (oc3),
        .oc1n           (oc1n),
        .oc2n           (oc2n),
        .oc3n           (oc3n),
        .fault_detected (fault_detected),
        .int_status_brk (int_status_brk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_fault_pulses = 0;

    always @(posedge clk) if (rst_n && fault_detected) n_fault_pulses++;

    typedef struct packed {
        logic [2:0] refv, cce, ccne, ccp, ccnp, ois, oisn;
        logic       moe;
        logic [2:0] exp_oc, exp_ocn;
    } vec_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] oc;
        logic [2:0] ocn;
    } sb_t;

    vec_t       tbl [7];
    sb_t        sb_q[$];
    logic [2:0] ref_hist [HN];
    int         cyc = 0;
    int         valid_from = 0;
    int         run_left [3] = '{0, 0, 0};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic adv(input int n);
        for (int k = 0; k < n; k++) begin
            ref_hist[cyc % HN] = ref_v;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // A leg is on only after ref held its level for dtg+1 samples, seen two clocks later.
    task automatic step();
        sb_t        e, got;
        logic [2:0] m, c;
        int         lo;
        lo = cyc - 1 - int'(dtg);
        e.vld = (lo >= valid_from);
        m = 3'b111;
        c = 3'b111;
        if (e.vld) begin
            for (int j = lo; j <= cyc - 1; j++) begin
                m = m & ref_hist[j % HN];
                c = c & ~ref_hist[j % HN];
            end
        end
        for (int i = 0; i < 3; i++) begin
            e.oc[i]  = moe ? (cce[i]  ? (m[i] ^ ccp[i])  : ccp[i])  : ois[i];
            e.ocn[i] = moe ? (ccne[i] ? (c[i] ^ ccnp[i]) : ccnp[i]) : oisn[i];
        end
        sb_q.push_back(e);
        adv(1);
        got = sb_q.pop_front();
        if (got.vld) begin
            chk("pwm_oc",  {5'b0, oc_v},  {5'b0, got.oc});
            chk("pwm_ocn", {5'b0, ocn_v}, {5'b0, got.ocn});
        end
    endtask

    task automatic run_phase(input int n, input int rmin, input int rmax);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < 3; i++) begin
                if (run_left[i] == 0) begin
                    ref_v[i]    = ~ref_v[i];
                    run_left[i] = $urandom_range(rmax, rmin);
                end
                run_left[i]--;
            end
            step();
        end
    endtask

    initial begin
        int fp0;
        tbl[0] = '{3'b101, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1, 3'b101, 3'b010};
        tbl[1] = '{3'b101, 3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000, 1'b1, 3'b010, 3'b010};
        tbl[2] = '{3'b011, 3'b111, 3'b101, 3'b000, 3'b010, 3'b000, 3'b000, 1'b1, 3'b011, 3'b110};
        tbl[3] = '{3'b011, 3'b111, 3'b111, 3'b000, 3'b000, 3'b101, 3'b010, 1'b0, 3'b101, 3'b010};
        tbl[4] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b001, 3'b000, 3'b000, 1'b1, 3'b110, 3'b110};
        tbl[5] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b111, 3'b000, 3'b000, 1'b1, 3'b111, 3'b111};
        tbl[6] = '{3'b111, 3'b111, 3'b111, 3'b000, 3'b000, 3'b010, 3'b111, 1'b0, 3'b010, 3'b111};

        rst_n = 1'b0;  ref_v = 3'b000; dtg = 8'd2;
        cce = 3'b111;  ccne = 3'b111;  ccp = 3'b000; ccnp = 3'b000;
        ois = 3'b000;  oisn = 3'b000;  moe = 1'b0;
        bke = 1'b0;    bkp = 1'b1;     bkf = 4'd0;   brk_clr = 1'b0; brk_in = 1'b0;

        #13;
        chk("reset_oc",    {5'b0, oc_v},  8'h00);
        chk("reset_ocn",   {5'b0, ocn_v}, 8'h00);
        chk("reset_fault", {7'b0, fault_detected}, 8'h00);
        chk("reset_brk",   {7'b0, int_status_brk}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        adv(4);

        // Steady-state output mux vectors
        for (int v = 0; v < 7; v++) begin
            ref_v = tbl[v].refv; cce = tbl[v].cce; ccne = tbl[v].ccne;
            ccp = tbl[v].ccp; ccnp = tbl[v].ccnp; ois = tbl[v].ois;
            oisn = tbl[v].oisn; moe = tbl[v].moe;
            adv(8);
            chk($sformatf("vec%0d_oc", v),  {5'b0, oc_v},  {5'b0, tbl[v].exp_oc});
            chk($sformatf("vec%0d_ocn", v), {5'b0, ocn_v}, {5'b0, tbl[v].exp_ocn});
        end

        // Dead time 5 with random run lengths, including sub-dead-time pulses
        cce = 3'b111; ccne = 3'b111; ccp = 3'b000; ccnp = 3'b000; moe = 1'b1;
        ref_v = 3'b000;
        adv(10);
        dtg = 8'd5;
        valid_from = cyc;
        for (int k = 0; k < 8; k++) step();
        ref_v[0] = 1'b1;
        for (int k = 0; k < 10; k++) step();
        ref_v[0] = 1'b0;
        for (int k = 0; k < 10; k++) step();
        run_phase(150, 1, 12);

        // Dead time 6, single 3-clock pulse on channel 1
        ref_v = 3'b000;
        adv(12);
        dtg = 8'd6;
        valid_from = cyc;
        for (int k = 0; k < 10; k++) step();
        ref_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) step();
        ref_v[0] = 1'b0;
        for (int k = 0; k < 14; k++) step();
        run_phase(100, 1, 10);

        // Zero dead time, active-low main polarity
        ref_v = 3'b000;
        adv(10);
        dtg = 8'd0; ccp = 3'b111;
        valid_from = cyc;
        run_phase(100, 1, 4);

        // Break, no filter
        ccp = 3'b000; dtg = 8'd2; ref_v = 3'b011; ois = 3'b101; oisn = 3'b010;
        adv(10);
        chk("pre_brk_oc", {5'b0, oc_v}, 8'h03);
        bke = 1'b1; bkp = 1'b1; bkf = 4'd0;
        fp0 = n_fault_pulses;
        brk_in = 1'b1;
        adv(2);
        chk("brk_fault_t2", {7'b0, fault_detected}, 8'h00);
        adv(1);
        chk("brk_fault_t3", {7'b0, fault_detected}, 8'h01);
        chk("brk_latch_t3", {7'b0, int_status_brk}, 8'h01);
        adv(1);
        chk("brk_fault_t4", {7'b0, fault_detected}, 8'h00);
        chk("brk_idle_oc",  {5'b0, oc_v},  8'h05);
        chk("brk_idle_ocn", {5'b0, ocn_v}, 8'h02);
        brk_in = 1'b0;
        adv(6);
        chk("brk_sticky",  {7'b0, int_status_brk}, 8'h01);
        chk("brk_npulses", 8'(n_fault_pulses - fp0), 8'h01);
        brk_clr = 1'b1;
        adv(1);
        brk_clr = 1'b0;
        chk("brk_clr1", {7'b0, int_status_brk}, 8'h00);

        // Break filter of 4
        bkf = 4'd4;
        fp0 = n_fault_pulses;
        brk_in = 1'b1;
        adv(3);
        brk_in = 1'b0;
        adv(6);
        chk("flt_short", {7'b0, int_status_brk}, 8'h00);
        chk("flt_short_pulses", 8'(n_fault_pulses - fp0), 8'h00);
        brk_in = 1'b1;
        adv(6);
        chk("flt_long", {7'b0, int_status_brk}, 8'h01);
        brk_clr = 1'b1;
        adv(1);
        brk_clr = 1'b0;
        chk("flt_clr_ignored", {7'b0, int_status_brk}, 8'h01);
        brk_in = 1'b0;
        adv(4);
        chk("flt_sticky", {7'b0, int_status_brk}, 8'h01);
        brk_clr = 1'b1;
        adv(1);
        brk_clr = 1'b0;
        chk("flt_clr", {7'b0, int_status_brk}, 8'h00);
        adv(1);
        chk("resume_oc",  {5'b0, oc_v},  8'h03);
        chk("resume_ocn", {5'b0, ocn_v}, 8'h04);
        chk("flt_npulses", 8'(n_fault_pulses - fp0), 8'h01);

        // Break disabled: latch never sets
        bke = 1'b0; bkf = 4'd0;
        brk_in = 1'b1;
        adv(6);
        chk("bke0_latch", {7'b0, int_status_brk}, 8'h00);
        brk_in = 1'b0;
        adv(3);

        // Async reset mid-operation
        moe = 1'b0; ois = 3'b111; oisn = 3'b111; bke = 1'b1;
        brk_in = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ref_v = ~ref_v;
            adv(1);
        end
        chk("prerst_oc",  {5'b0, oc_v},  8'h07);
        chk("prerst_ocn", {5'b0, ocn_v}, 8'h07);
        chk("prerst_brk", {7'b0, int_status_brk}, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_oc",  {5'b0, oc_v},  8'h00);
        chk("arst_ocn", {5'b0, ocn_v}, 8'h00);
        chk("arst_brk", {7'b0, int_status_brk}, 8'h00);
        @(posedge clk);
        #1;
        brk_in = 1'b0;
        rst_n = 1'b1;
        adv(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
